systolic_feeder: RTL and testbench

- Edge feeder that drives one edge (A rows or B columns) of the systolic PE array.
- Accepts one LANES-wide vector per handshake and emits it skewed: lane i is delayed i cycles relative to lane 0.
- Generates the per-lane clear pulse aligned with the first element of each tile, so every PE restarts accumulation exactly on the tile boundary.
- Two instances (A edge, B edge) are driven in lockstep by the tile controller.

---
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewed edge feeder for the systolic PE array: lane i lags lane 0 by i cycles, with a per-lane tile clear.
// Optional build macro FEEDER_BUBBLE_CHECK_EN adds a sticky err_o for input bubbles inside a tile.
//
//  state  | meaning
//  IDLE   | no tile in flight; next accepted beat is the tile's first (clear)
//  STREAM | mid-tile; accepting beats until one carries in_last_i
//  DRAIN  | last beat taken; input held off while the skew registers empty
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module systolic_feeder #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_last_i,
    input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
    output logic [LANES*DATA_WIDTH-1:0] data_o,
    output logic [LANES-1:0]            clear_o,
    output logic                        busy_o,
    output logic                        tile_done_o,
    output logic                        err_o
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               first;
    logic [LANES-1:0]   last_sr;

    assign in_ready_o = (state_q != DRAIN);
    assign busy_o     = (state_q != IDLE);
    assign accept     = in_valid_i && in_ready_o;
    assign first      = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds LANES-1 on DRAIN entry; DRAIN ends once it would tick to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last_i) begin
                        if (LANES > 1) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_W'(LANES - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Triangular skew array: lane i is an (i+1)-deep register chain.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] d_sr [i+1];
        logic [i:0]            c_sr;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= i; j++) begin
                    d_sr[j] <= '0;
                end
                c_sr <= '0;
            end else begin
                d_sr[0] <= accept ? in_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                c_sr[0] <= accept && first;
                for (int j = 1; j <= i; j++) begin
                    d_sr[j] <= d_sr[j-1];
                    c_sr[j] <= c_sr[j-1];
                end
            end
        end

        assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = d_sr[i];
        assign clear_o[i]                         = c_sr[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_sr <= '0;
        end else begin
            last_sr[0] <= accept && in_last_i;
            for (int j = 1; j < LANES; j++) begin
                last_sr[j] <= last_sr[j-1];
            end
        end
    end

    assign tile_done_o = last_sr[LANES-1];

`ifdef FEEDER_BUBBLE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (state_q == STREAM && !in_valid_i) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: cycle tables for a 4-lane instance plus a 1-lane instance.
module tb_systolic_feeder;

    localparam int W = 16;
`ifdef FEEDER_BUBBLE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld, lst;
    logic [4*W-1:0] din;
    logic          rdy, busy, done, err;
    logic [4*W-1:0] dout;
    logic [3:0]    clr;

    logic          v1, l1;
    logic [W-1:0]  d1, q1;
    logic          r1, b1, dn1, e1;
    logic [0:0]    c1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.LANES(4), .DATA_WIDTH(W)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_ready_o(rdy),
        .in_last_i(lst), .in_data_i(din), .data_o(dout), .clear_o(clr),
        .busy_o(busy), .tile_done_o(done), .err_o(err)
    );

    systolic_feeder #(.LANES(1), .DATA_WIDTH(W)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .in_ready_o(r1),
        .in_last_i(l1), .in_data_i(d1), .data_o(q1), .clear_o(c1),
        .busy_o(b1), .tile_done_o(dn1), .err_o(e1)
    );

    typedef struct {
        string       name;
        logic        vld;
        logic        lst;
        logic [63:0] din;
        logic [63:0] e_data;
        logic [3:0]  e_clr;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic        e_bub;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic v, logic l, logic [63:0] d, logic [63:0] ed,
                                logic [3:0] ec, logic er, logic eb, logic edn, logic ebub);
        vec_t t;
        t.name = n; t.vld = v; t.lst = l; t.din = d; t.e_data = ed; t.e_clr = ec;
        t.e_rdy = er; t.e_busy = eb; t.e_done = edn; t.e_bub = ebub;
        return t;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] B0 = 64'h0400_0300_0200_0100;
    localparam logic [63:0] B1 = 64'h0410_0310_0210_0110;
    localparam logic [63:0] B2 = 64'h0420_0320_0220_0120;
    localparam logic [63:0] X0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] X1 = 64'h8004_FF03_8002_FFFF;
    localparam logic [63:0] T0 = 64'h0A04_0A03_0A02_0A01;
    localparam logic [63:0] T1 = 64'h0B04_0B03_0B02_0B01;

    logic [15:0] e1_data [4];
    logic        e1_clr  [4];
    logic        e1_done [4];
    logic        e1_busy [4];

    initial begin
        // K=3 tile
        tbl.push_back(mk("k3_c0", 1, 0, B0, 64'h0, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(mk("k3_c1", 1, 0, B1, 64'h0000_0000_0000_0100, 4'b0001, 1, 1, 0, 0));
        tbl.push_back(mk("k3_c2", 1, 1, B2, 64'h0000_0000_0200_0110, 4'b0010, 1, 1, 0, 0));
        tbl.push_back(mk("k3_c3", 0, 0, 0,  64'h0000_0300_0210_0120, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk("k3_c4", 0, 0, 0,  64'h0400_0310_0220_0000, 4'b1000, 0, 1, 0, 0));
        tbl.push_back(mk("k3_c5", 0, 0, 0,  64'h0410_0320_0000_0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk("k3_c6", 0, 0, 0,  64'h0420_0000_0000_0000, 4'b0000, 1, 0, 1, 0));
        tbl.push_back(mk("k3_c7", 0, 0, 0,  64'h0, 4'b0000, 1, 0, 0, 0));
        // STREAM bubble at cycle 1
        tbl.push_back(mk("bub_c0", 1, 0, X0, 64'h0, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(mk("bub_c1", 0, 0, 0,  64'h0000_0000_0000_0001, 4'b0001, 1, 1, 0, 0));
        tbl.push_back(mk("bub_c2", 1, 1, X1, 64'h0000_0000_0002_0000, 4'b0010, 1, 1, 0, 1));
        tbl.push_back(mk("bub_c3", 0, 0, 0,  64'h0000_0003_0000_FFFF, 4'b0100, 0, 1, 0, 1));
        tbl.push_back(mk("bub_c4", 0, 0, 0,  64'h0004_0000_8002_0000, 4'b1000, 0, 1, 0, 1));
        tbl.push_back(mk("bub_c5", 0, 0, 0,  64'h0000_FF03_0000_0000, 4'b0000, 0, 1, 0, 1));
        tbl.push_back(mk("bub_c6", 0, 0, 0,  64'h8004_0000_0000_0000, 4'b0000, 1, 0, 1, 1));
        tbl.push_back(mk("bub_c7", 0, 0, 0,  64'h0, 4'b0000, 1, 0, 0, 1));
        // back-to-back tiles, next beat held on the input during DRAIN
        tbl.push_back(mk("b2b_c0",  1, 0, B0, 64'h0, 4'b0000, 1, 0, 0, 1));
        tbl.push_back(mk("b2b_c1",  1, 0, B1, 64'h0000_0000_0000_0100, 4'b0001, 1, 1, 0, 1));
        tbl.push_back(mk("b2b_c2",  1, 1, B2, 64'h0000_0000_0200_0110, 4'b0010, 1, 1, 0, 1));
        tbl.push_back(mk("b2b_c3",  1, 0, T0, 64'h0000_0300_0210_0120, 4'b0100, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c4",  1, 0, T0, 64'h0400_0310_0220_0000, 4'b1000, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c5",  1, 0, T0, 64'h0410_0320_0000_0000, 4'b0000, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c6",  1, 0, T0, 64'h0420_0000_0000_0000, 4'b0000, 1, 0, 1, 1));
        tbl.push_back(mk("b2b_c7",  1, 1, T1, 64'h0000_0000_0000_0A01, 4'b0001, 1, 1, 0, 1));
        tbl.push_back(mk("b2b_c8",  0, 0, 0,  64'h0000_0000_0A02_0B01, 4'b0010, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c9",  0, 0, 0,  64'h0000_0A03_0B02_0000, 4'b0100, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c10", 0, 0, 0,  64'h0A04_0B03_0000_0000, 4'b1000, 0, 1, 0, 1));
        tbl.push_back(mk("b2b_c11", 0, 0, 0,  64'h0B04_0000_0000_0000, 4'b0000, 1, 0, 1, 1));
        tbl.push_back(mk("b2b_c12", 0, 0, 0,  64'h0, 4'b0000, 1, 0, 0, 1));

        rst_n = 1'b0; vld = 1'b0; lst = 1'b0; din = '0;
        v1 = 1'b0; l1 = 1'b0; d1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle%0d.data", c), dout, 64'h0);
            chk($sformatf("idle%0d.clear", c), clr, 4'b0000);
            chk($sformatf("idle%0d.ready", c), rdy, 1'b1);
            chk($sformatf("idle%0d.busy", c), busy, 1'b0);
            chk($sformatf("idle%0d.done", c), done, 1'b0);
            chk($sformatf("idle%0d.err", c), err, 1'b0);
            next_cycle();
        end

        foreach (tbl[k]) begin
            vld = tbl[k].vld; lst = tbl[k].lst; din = tbl[k].din;
            @(negedge clk);
            chk({tbl[k].name, ".data"},  dout, tbl[k].e_data);
            chk({tbl[k].name, ".clear"}, clr,  tbl[k].e_clr);
            chk({tbl[k].name, ".ready"}, rdy,  tbl[k].e_rdy);
            chk({tbl[k].name, ".busy"},  busy, tbl[k].e_busy);
            chk({tbl[k].name, ".done"},  done, tbl[k].e_done);
            chk({tbl[k].name, ".err"},   err,  tbl[k].e_bub & ERR_EN);
            next_cycle();
        end
        vld = 1'b0; lst = 1'b0; din = '0;

        // reset in cycle 3 of a K=3 tile, released in cycle 5
        vld = 1'b1; din = B0; next_cycle();
        din = B1; next_cycle();
        lst = 1'b1; din = B2; next_cycle();
        vld = 1'b0; lst = 1'b0; din = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_assert.data", dout, 64'h0);
        chk("rst_assert.clear", clr, 4'b0000);
        chk("rst_assert.busy", busy, 1'b0);
        chk("rst_assert.done", done, 1'b0);
        chk("rst_assert.err", err, 1'b0);
        for (int c = 3; c < 9; c++) begin
            if (c == 5) rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("rst_c%0d.data", c), dout, 64'h0);
            chk($sformatf("rst_c%0d.clear", c), clr, 4'b0000);
            chk($sformatf("rst_c%0d.done", c), done, 1'b0);
            chk($sformatf("rst_c%0d.busy", c), busy, 1'b0);
            if (c >= 5) chk($sformatf("rst_c%0d.ready", c), rdy, 1'b1);
            next_cycle();
        end

        // LANES=1, K=2 tile
        e1_data = '{16'h0000, 16'h1234, 16'hABCD, 16'h0000};
        e1_clr  = '{1'b0, 1'b1, 1'b0, 1'b0};
        e1_done = '{1'b0, 1'b0, 1'b1, 1'b0};
        e1_busy = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            v1 = (c < 2);
            l1 = (c == 1);
            d1 = (c == 0) ? 16'h1234 : (c == 1) ? 16'hABCD : 16'h0000;
            @(negedge clk);
            chk($sformatf("l1_c%0d.data", c), q1, e1_data[c]);
            chk($sformatf("l1_c%0d.clear", c), c1, e1_clr[c]);
            chk($sformatf("l1_c%0d.done", c), dn1, e1_done[c]);
            chk($sformatf("l1_c%0d.busy", c), b1, e1_busy[c]);
            chk($sformatf("l1_c%0d.ready", c), r1, 1'b1);
            chk($sformatf("l1_c%0d.err", c), e1, 1'b0);
            next_cycle();
        end
        v1 = 1'b0; l1 = 1'b0; d1 = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
